// File: rtl/dm_rmw_bridge.sv
// CPU data-memory to single-port SRAM bridge: loads, full-word stores, and
// read-modify-write for partial stores, plus a sticky halt flag and RMW counter.
module dm_rmw_bridge #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_w_en,
    output logic [ADDR_W-1:0] sram_address,
    output logic [DATA_W-1:0] sram_write_data,
    input  logic [DATA_W-1:0] sram_read_data,
    output logic              halt,
    output logic [15:0]       rmw_count,
    output logic [2:0]        dbg_state
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ADDR = 3'd1;
    localparam logic [2:0] S_RD_RESP = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_RMW_RD  = 3'd4;
    localparam logic [2:0] S_RMW_WR  = 3'd5;

    localparam logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(16'hFFFC);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              halt_q, halt_d;
    logic [15:0]       rmw_q, rmw_d;

    logic              accept;
    logic [DATA_W-1:0] merged;
    logic [DATA_W-1:0] wr_data;
    logic              w_en;

    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_ready is only high in IDLE out of reset, and
    // the request fields are don't-care once that edge has passed.
    assign req_ready = (state_q == S_IDLE) && rst;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!req_we) begin
                        state_d = S_RD_ADDR;
                    end else if (req_be == 4'b1111 || req_be == 4'b0000) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_RD_ADDR: state_d = S_RD_RESP;
            S_RD_RESP: state_d = S_IDLE;
            S_WR:      state_d = S_IDLE;
            S_RMW_RD:  state_d = S_RMW_WR;
            S_RMW_WR:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        if (accept) begin
            addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            be_d    = req_be;
            wdata_d = req_wdata;
        end
    end

    // Read data arrives the cycle after RMW_RD drives the address, i.e. in RMW_WR.
    always_comb begin
        merged = '0;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be_q[i] ? wdata_q[8*i +: 8] : sram_read_data[8*i +: 8];
        end
    end

    always_comb begin
        wr_data = '0;
        w_en    = 1'b0;
        if (state_q == S_WR) begin
            wr_data = wdata_q;
            w_en    = |be_q;
        end else if (state_q == S_RMW_WR) begin
            wr_data = merged;
            w_en    = 1'b1;
        end
    end

    always_comb begin
        halt_d = halt_q;
        if (w_en && addr_q == HALT_ADDR && wr_data[7:0] == 8'hFF) begin
            halt_d = 1'b1;
        end
        rmw_d = rmw_q;
        if (state_q == S_RMW_WR && rmw_q != 16'hFFFF) begin
            rmw_d = rmw_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            halt_q  <= 1'b0;
            rmw_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            halt_q  <= halt_d;
            rmw_q   <= rmw_d;
        end
    end

    assign rsp_valid       = (state_q == S_RD_RESP) || (state_q == S_WR) || (state_q == S_RMW_WR);
    assign rsp_rdata       = (state_q == S_RD_RESP) ? sram_read_data : '0;
    assign sram_w_en       = w_en;
    assign sram_address    = addr_q;
    assign sram_write_data = wr_data;
    assign halt            = halt_q;
    assign rmw_count       = rmw_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_dm_rmw_bridge.sv
// Self-checking bench for dm_rmw_bridge with a behavioural SRAM, a load-data
// scoreboard queue and one task per scenario.
module tb_dm_rmw_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        sram_w_en;
    logic [15:0] sram_address;
    logic [31:0] sram_write_data;
    logic [31:0] sram_read_data;
    logic        halt;
    logic [15:0] rmw_count;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int exp_rmw  = 0;

    logic [31:0] exp_q[$];
    logic [31:0] mem[int];
    logic [31:0] exp_mem[int];

    dm_rmw_bridge #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sram_w_en(sram_w_en), .sram_address(sram_address),
        .sram_write_data(sram_write_data), .sram_read_data(sram_read_data),
        .halt(halt), .rmw_count(rmw_count), .dbg_state(dbg_state)
    );

    // clock / reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // synchronous-read SRAM: data for the address seen at an edge appears after it
    always @(posedge clk) begin
        if (mem.exists(int'(sram_address))) sram_read_data <= mem[int'(sram_address)];
        else sram_read_data <= 32'h0;
        if (sram_w_en === 1'b1) mem[int'(sram_address)] = sram_write_data;
    end

    function automatic logic [31:0] mem_rd(input logic [15:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return 32'h0;
    endfunction

    // driver: one request, then watch up to 8 cycles for writes and the response
    task automatic drive_req(input logic we, input logic [15:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                             output int n_wr, output int wr_lat, output logic [15:0] wr_addr,
                             output logic [31:0] wr_data);
        int  guard;
        bit  done;
        lat = -1; rdata = 32'h0; n_wr = 0; wr_lat = -1; wr_addr = 16'h0; wr_data = 32'h0;
        guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (req_ready !== 1'b1) return;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_be    = 4'($urandom_range(0, 15));
        req_wdata = $urandom;
        done = 1'b0;
        for (int i = 1; i <= 8 && !done; i++) begin
            @(negedge clk);
            if (sram_w_en === 1'b1) begin
                n_wr++; wr_lat = i; wr_addr = sram_address; wr_data = sram_write_data;
            end
            if (rsp_valid === 1'b1) begin
                lat = i; rdata = rsp_rdata; done = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0; req_be = 4'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || sram_w_en !== 1'b0) $display("FAIL reset_ctrl: got ready=%b rsp=%b wen=%b want 0 0 0", req_ready, rsp_valid, sram_w_en);
        else n_pass++;
        n_checks++;
        if (sram_address !== 16'h0 || sram_write_data !== 32'h0 || rsp_rdata !== 32'h0) $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", sram_address, sram_write_data, rsp_rdata);
        else n_pass++;
        n_checks++;
        if (halt !== 1'b0 || rmw_count !== 16'h0 || dbg_state !== 3'd0) $display("FAIL reset_status: got halt=%b rmw=%h state=%0d want 0 0 0", halt, rmw_count, dbg_state);
        else n_pass++;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL first_ready: got %b want 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_load();
        int lat, n_wr, wr_lat; logic [31:0] rdata, wr_data, exp; logic [15:0] wr_addr;
        mem[16'h9004] = 32'hDEADBEEF;
        exp_q.push_back(32'hDEADBEEF);
        drive_req(1'b0, 16'h9006, 4'h0, 32'h0, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
        exp = exp_q.pop_front();
        n_checks++;
        if (lat !== 2) $display("FAIL load_lat: got %0d want 2", lat); else n_pass++;
        n_checks++;
        if (rdata !== exp) $display("FAIL load_data: got %h want %h", rdata, exp); else n_pass++;
        n_checks++;
        if (n_wr !== 0) $display("FAIL load_nowrite: got %0d writes want 0", n_wr); else n_pass++;
    endtask

    task automatic test_full_store();
        int lat, n_wr, wr_lat; logic [31:0] rdata, wr_data; logic [15:0] wr_addr;
        drive_req(1'b1, 16'h9000, 4'hF, 32'h12345678, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
        n_checks++;
        if (lat !== 1 || n_wr !== 1 || wr_lat !== 1) $display("FAIL full_timing: got lat=%0d writes=%0d wlat=%0d want 1 1 1", lat, n_wr, wr_lat); else n_pass++;
        n_checks++;
        if (wr_addr !== 16'h9000 || wr_data !== 32'h12345678) $display("FAIL full_write: got %h@%h want 12345678@9000", wr_data, wr_addr); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rmw_count !== 16'(exp_rmw)) $display("FAIL full_rmw: got %0d want %0d", rmw_count, exp_rmw); else n_pass++;
        n_checks++;
        if (mem_rd(16'h9000) !== 32'h12345678) $display("FAIL full_mem: got %h want 12345678", mem_rd(16'h9000)); else n_pass++;
    endtask

    task automatic test_partial_store();
        int lat, n_wr, wr_lat; logic [31:0] rdata, wr_data; logic [15:0] wr_addr;
        mem[16'h9010] = 32'h11223344;
        drive_req(1'b1, 16'h9010, 4'b0010, 32'h0000AB00, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
        exp_rmw++;
        n_checks++;
        if (lat !== 2 || n_wr !== 1 || wr_lat !== 2) $display("FAIL rmw_timing: got lat=%0d writes=%0d wlat=%0d want 2 1 2", lat, n_wr, wr_lat); else n_pass++;
        n_checks++;
        if (wr_data !== 32'h1122AB44 || wr_addr !== 16'h9010) $display("FAIL rmw_merge: got %h@%h want 1122ab44@9010", wr_data, wr_addr); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rmw_count !== 16'(exp_rmw)) $display("FAIL rmw_count: got %0d want %0d", rmw_count, exp_rmw); else n_pass++;
    endtask

    task automatic test_zero_be();
        int lat, n_wr, wr_lat; logic [31:0] rdata, wr_data; logic [15:0] wr_addr;
        mem[16'h9014] = 32'hCAFEF00D;
        drive_req(1'b1, 16'h9014, 4'h0, 32'hFFFFFFFF, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
        n_checks++;
        if (lat !== 1 || n_wr !== 0) $display("FAIL zero_be: got lat=%0d writes=%0d want 1 0", lat, n_wr); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rmw_count !== 16'(exp_rmw) || mem_rd(16'h9014) !== 32'hCAFEF00D) $display("FAIL zero_be_state: got rmw=%0d mem=%h want %0d cafef00d", rmw_count, mem_rd(16'h9014), exp_rmw); else n_pass++;
    endtask

    task automatic test_halt();
        int lat, n_wr, wr_lat; logic [31:0] rdata, wr_data, exp; logic [15:0] wr_addr;
        drive_req(1'b1, 16'hFFFC, 4'hF, 32'h000000FE, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
        @(negedge clk);
        n_checks++;
        if (halt !== 1'b0 || n_wr !== 1) $display("FAIL halt_fe: got halt=%b writes=%0d want 0 1", halt, n_wr); else n_pass++;
        mem[16'hFFFC] = 32'h12345678;
        drive_req(1'b1, 16'hFFFE, 4'b0001, 32'h000000FF, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
        exp_rmw++;
        n_checks++;
        if (wr_data !== 32'h123456FF || wr_lat !== 2) $display("FAIL halt_write: got %h wlat=%0d want 123456ff 2", wr_data, wr_lat); else n_pass++;
        n_checks++;
        if (halt !== 1'b0) $display("FAIL halt_early: got %b want 0", halt); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (halt !== 1'b1 || rmw_count !== 16'(exp_rmw)) $display("FAIL halt_set: got halt=%b rmw=%0d want 1 %0d", halt, rmw_count, exp_rmw); else n_pass++;
        exp_q.push_back(32'h123456FF);
        drive_req(1'b0, 16'hFFFC, 4'h0, 32'h0, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
        exp = exp_q.pop_front();
        @(negedge clk);
        n_checks++;
        if (rdata !== exp || halt !== 1'b1) $display("FAIL halt_sticky: got data=%h halt=%b want %h 1", rdata, halt, exp); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] addrs[3];
        int acc_cyc[3];
        int acc, nrsp;
        bit will;
        logic [31:0] exp;
        for (int k = 0; k < 3; k++) begin
            addrs[k] = 16'h9100 + 16'(4 * k);
            mem[int'(addrs[k])] = $urandom;
            exp_q.push_back(mem[int'(addrs[k])]);
            acc_cyc[k] = 0;
        end
        acc = 0; nrsp = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_we = 1'b0; req_addr = addrs[0]; req_be = 4'h0;
        for (int i = 0; i < 40 && nrsp < 3; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
                n_checks++;
                if (rsp_rdata !== exp) $display("FAIL b2b_data%0d: got %h want %h", nrsp, rsp_rdata, exp); else n_pass++;
                nrsp++;
            end
            will = (req_ready === 1'b1 && req_valid === 1'b1);
            if (will) acc_cyc[acc] = cyc;
            @(posedge clk);
            #1;
            if (will) begin
                acc++;
                if (acc < 3) req_addr = addrs[acc];
                else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        n_checks++;
        if (nrsp !== 3 || acc !== 3) $display("FAIL b2b_count: got rsp=%0d acc=%0d want 3 3", nrsp, acc); else n_pass++;
        n_checks++;
        if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) $display("FAIL b2b_spacing: got %0d %0d want 3 3", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit bad;
        mem[16'h9020] = 32'hAABBCCDD;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h9020; req_be = 4'b0100; req_wdata = 32'h00EE0000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        n_checks++;
        if (dbg_state !== 3'd4) $display("FAIL mid_state: got %0d want 4", dbg_state); else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (sram_w_en !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0 || dbg_state !== 3'd0) $display("FAIL mid_abort: got wen=%b rsp=%b ready=%b state=%0d want 0 0 0 0", sram_w_en, rsp_valid, req_ready, dbg_state); else n_pass++;
        n_checks++;
        if (halt !== 1'b0 || rmw_count !== 16'h0 || sram_address !== 16'h0 || sram_write_data !== 32'h0) $display("FAIL mid_outputs: got halt=%b rmw=%0d addr=%h wdata=%h want 0", halt, rmw_count, sram_address, sram_write_data); else n_pass++;
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || sram_w_en !== 1'b0) bad = 1'b1;
        end
        @(posedge clk);
        #1 rst = 1'b1;
        exp_rmw = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || sram_w_en !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) $display("FAIL mid_no_rsp: got stray rsp_valid or sram_w_en want none"); else n_pass++;
        n_checks++;
        if (mem_rd(16'h9020) !== 32'hAABBCCDD || rmw_count !== 16'h0 || halt !== 1'b0) $display("FAIL mid_after: got mem=%h rmw=%0d halt=%b want aabbccdd 0 0", mem_rd(16'h9020), rmw_count, halt); else n_pass++;
    endtask

    task automatic test_random();
        int lat, n_wr, wr_lat, op, k; logic [31:0] rdata, wr_data, wd, exp, mrg; logic [15:0] wr_addr, a; logic [3:0] be;
        for (int j = 0; j < 4; j++) begin
            mem[16'h8000 + 4 * j] = $urandom;
            exp_mem[16'h8000 + 4 * j] = mem[16'h8000 + 4 * j];
        end
        for (int n = 0; n < 24; n++) begin
            op = $urandom_range(0, 3);
            k  = $urandom_range(0, 3);
            a  = 16'h8000 + 16'(4 * k) + 16'($urandom_range(0, 3));
            wd = $urandom;
            case (op)
                0: begin
                    exp_q.push_back(exp_mem[16'h8000 + 4 * k]);
                    drive_req(1'b0, a, 4'h0, 32'h0, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
                    exp = exp_q.pop_front();
                    n_checks++;
                    if (lat !== 2 || rdata !== exp) $display("FAIL rnd_load%0d: got lat=%0d data=%h want 2 %h", n, lat, rdata, exp); else n_pass++;
                end
                1: begin
                    exp_mem[16'h8000 + 4 * k] = wd;
                    drive_req(1'b1, a, 4'hF, wd, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
                    n_checks++;
                    if (lat !== 1 || n_wr !== 1 || wr_data !== wd) $display("FAIL rnd_full%0d: got lat=%0d writes=%0d data=%h want 1 1 %h", n, lat, n_wr, wr_data, wd); else n_pass++;
                end
                2: begin
                    be  = 4'($urandom_range(1, 14));
                    mrg = exp_mem[16'h8000 + 4 * k];
                    for (int l = 0; l < 4; l++) if (be[l]) mrg[8*l +: 8] = wd[8*l +: 8];
                    exp_mem[16'h8000 + 4 * k] = mrg;
                    exp_rmw++;
                    drive_req(1'b1, a, be, wd, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
                    n_checks++;
                    if (lat !== 2 || n_wr !== 1 || wr_data !== mrg) $display("FAIL rnd_rmw%0d: got lat=%0d writes=%0d data=%h want 2 1 %h", n, lat, n_wr, wr_data, mrg); else n_pass++;
                end
                default: begin
                    drive_req(1'b1, a, 4'h0, wd, lat, rdata, n_wr, wr_lat, wr_addr, wr_data);
                    n_checks++;
                    if (lat !== 1 || n_wr !== 0) $display("FAIL rnd_zero%0d: got lat=%0d writes=%0d want 1 0", n, lat, n_wr); else n_pass++;
                end
            endcase
        end
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (mem_rd(16'h8000 + 16'(4 * j)) !== exp_mem[16'h8000 + 4 * j]) $display("FAIL rnd_mem%0d: got %h want %h", j, mem_rd(16'h8000 + 16'(4 * j)), exp_mem[16'h8000 + 4 * j]); else n_pass++;
        end
        n_checks++;
        if (rmw_count !== 16'(exp_rmw)) $display("FAIL rnd_rmw_count: got %0d want %0d", rmw_count, exp_rmw); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load();
        test_full_store();
        test_partial_store();
        test_zero_be();
        test_halt();
        test_back_to_back();
        test_reset_mid();
        test_random();
        n_checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dm_rmw_bridge.md
DM_RMW_BRIDGE -- requirements
Module: dm_rmw_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, byte address width; DATA_W, 32, word width (fixed at 32; byte-lane logic assumes 4 lanes).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset (low = reset asserted).
REQ-004 req_valid  input  1  CPU data-memory request present.
REQ-005 req_ready  output  1  bridge can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  ADDR_W  byte address; bits [1:0] ignored.
REQ-008 req_be  input  4  store byte enables; lane i = bits [8i+7:8i]; ignored for loads.
REQ-009 req_wdata  input  32  store data, already lane-aligned.
REQ-010 rsp_valid  output  1  one-cycle completion pulse for load or store.
REQ-011 rsp_rdata  output  32  load data, valid only when rsp_valid and request was a load.
REQ-012 sram_w_en  output  1  SRAM word write enable.
REQ-013 sram_address  output  ADDR_W  SRAM address, always {addr[15:2],2'b00}.
REQ-014 sram_write_data  output  32  SRAM write word.
REQ-015 sram_read_data  input  32  SRAM read word; valid the cycle after the address was presented.
REQ-016 halt  output  1  sticky end-of-program flag.
REQ-017 rmw_count  output  16  number of committed read-modify-write stores.

Function
REQ-018 FSM states SHALL be IDLE, RD_ADDR, RD_RESP, WR, RMW_RD, RMW_WR.
REQ-019 req_ready SHALL be 1 only in IDLE with rst high; a request is accepted in cycle n when req_valid and req_ready are both 1.
REQ-020 On accept, req_we, address, req_be, req_wdata SHALL be registered; inputs are don't-care after acceptance.
REQ-021 Load: IDLE->RD_ADDR (cycle n+1, address driven, sram_w_en=0) ->RD_RESP (cycle n+2, rsp_valid=1, rsp_rdata=sram_read_data) ->IDLE.
REQ-022 Full store (be=4'b1111): IDLE->WR (cycle n+1, sram_w_en=1, sram_write_data=wdata, rsp_valid=1) ->IDLE.
REQ-023 Partial store (be nonzero, not 4'b1111): IDLE->RMW_RD (n+1, address driven, sram_w_en=0) ->RMW_WR (n+2, sram_w_en=1, rsp_valid=1) ->IDLE.
REQ-024 RMW merge: lane i of sram_write_data = wdata lane i if be[i] else sram_read_data lane i.
REQ-025 Store with be=4'b0000 SHALL go to WR with sram_w_en=0, rsp_valid=1 in n+1; no SRAM write, not counted.
REQ-026 Outside WR/RMW_WR, sram_w_en SHALL be 0; outside RD_RESP/WR/RMW_WR, rsp_valid SHALL be 0.
REQ-027 rmw_count SHALL increment by 1 on each RMW_WR cycle and saturate at 16'hFFFF.
REQ-028 halt SHALL set on any committed write (sram_w_en=1) to word 16'hFFFC whose written lane 0 equals 8'hFF; it SHALL remain set until reset.
REQ-029 Back-to-back: earliest next accept is the cycle after the rsp_valid cycle.

Reset
REQ-030 While rst low: state=IDLE, req_ready=0, rsp_valid=0, sram_w_en=0, sram_address=0, sram_write_data=0, rsp_rdata=0, halt=0, rmw_count=0.
REQ-031 Reset asserted mid-transaction SHALL abort immediately (asynchronously deassert sram_w_en); no response is issued for the aborted request.
REQ-032 First accept possible in the first cycle with rst high.

Verification
REQ-033 Load 0x9004 with SRAM word 0xDEADBEEF -> rsp_valid in n+2 only, rsp_rdata=0xDEADBEEF, sram_w_en never 1.
REQ-034 Store 0x12345678, be=1111 to 0x9000 -> single write in n+1, rsp_valid in n+1, rmw_count unchanged.
REQ-035 Store wdata=0x0000AB00, be=0010 to 0x9010 holding 0x11223344 -> read n+1, write 0x1122AB44 in n+2, rmw_count=1.
REQ-036 Store wdata=0x000000FF, be=0001 to 0xFFFC -> halt=1 after the n+2 edge and stays 1; subsequent loads do not clear it.
REQ-037 Assert rst during RMW_RD of a partial store -> no SRAM write, no rsp_valid, all outputs at reset values, rmw_count=0.
REQ-038 req_valid held high for three back-to-back loads -> accepts spaced exactly 3 cycles apart, responses in request order.
